// File: rtl/mmio_peripheral.sv
// Memory-mapped timer, LED, 7-segment display and system tick peripheral on the MEM-stage bus.
// Optional build macro LEADING_ZERO_BLANK_EN blanks display digits above the most significant non-zero nibble.
module mmio_peripheral #(
    parameter int          SCAN_DIV  = 100000,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rd_data,
    output logic [15:0] led,
    output logic [3:0]  AN,
    output logic [7:0]  BCD,
    output logic        irq
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGI    = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    logic [31:0]   th_r;
    logic [31:0]   tl_r;
    logic [2:0]    tcon_r;
    logic [15:0]   led_r;
    logic [15:0]   digi_r;
    logic [31:0]   systick_r;
    logic [CW-1:0] scan_cnt_r;
    logic [1:0]    idx_r;
    logic [3:0]    an_r;
    logic [7:0]    bcd_r;

    logic          sel_s;
    logic [2:0]    off_s;
    logic          wr_s;
    logic          tl_max_s;
    logic          scan_last_s;
    logic [1:0]    idx_nx_s;
    logic          unused_s;

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 8'hC0;
            4'h1:    seg7 = 8'hF9;
            4'h2:    seg7 = 8'hA4;
            4'h3:    seg7 = 8'hB0;
            4'h4:    seg7 = 8'h99;
            4'h5:    seg7 = 8'h92;
            4'h6:    seg7 = 8'h82;
            4'h7:    seg7 = 8'hF8;
            4'h8:    seg7 = 8'h80;
            4'h9:    seg7 = 8'h90;
            4'hA:    seg7 = 8'h88;
            4'hB:    seg7 = 8'h83;
            4'hC:    seg7 = 8'hC6;
            4'hD:    seg7 = 8'hA1;
            4'hE:    seg7 = 8'h86;
            4'hF:    seg7 = 8'h8E;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] digit_code(input logic [1:0] idx, input logic [15:0] value);
        logic [3:0] nib;
        logic       blank;
        case (idx)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            2'd3:    nib = value[15:12];
            default: nib = value[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // Digit 0 is never blanked so a zero value still shows a single "0".
        case (idx)
            2'd1:    blank = (value[15:4] == 12'd0);
            2'd2:    blank = (value[15:8] == 8'd0);
            2'd3:    blank = (value[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        digit_code = blank ? 8'hFF : seg7(nib);
    endfunction

    assign sel_s       = (addr[31:5] == BASE_ADDR[31:5]);
    assign off_s       = addr[4:2];
    assign wr_s        = mem_write & sel_s;
    assign tl_max_s    = (tl_r == 32'hFFFF_FFFF);
    assign scan_last_s = (scan_cnt_r == CW'(SCAN_DIV - 1));
    assign idx_nx_s    = idx_r + 2'd1;
    assign unused_s    = ^addr[1:0];

    // Combinational read mux, same-cycle semantics as data memory.
    always_comb begin
        rd_data = 32'd0;
        if (mem_read && sel_s) begin
            case (off_s)
                OFF_TH:      rd_data = th_r;
                OFF_TL:      rd_data = tl_r;
                OFF_TCON:    rd_data = {29'd0, tcon_r};
                OFF_LED:     rd_data = {16'd0, led_r};
                OFF_DIGI:    rd_data = {16'd0, digi_r};
                OFF_SYSTICK: rd_data = systick_r;
                default:     rd_data = 32'd0;
            endcase
        end else begin
            rd_data = 32'd0;
        end
    end

    // Timer: bus writes to TL/TCON take priority over counting, reload and status set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_r   <= 32'd0;
            tl_r   <= 32'd0;
            tcon_r <= 3'd0;
        end else begin
            if (wr_s && off_s == OFF_TH) begin
                th_r <= wr_data;
            end
            if (wr_s && off_s == OFF_TL) begin
                tl_r <= wr_data;
            end else if (tcon_r[0]) begin
                tl_r <= tl_max_s ? th_r : tl_r + 32'd1;
            end
            if (wr_s && off_s == OFF_TCON) begin
                tcon_r <= wr_data[2:0];
            end else if (tcon_r[0] && tcon_r[1] && tl_max_s) begin
                tcon_r[2] <= 1'b1;
            end
        end
    end

    // LED, display value and free-running tick; SYSTICK ignores writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_r     <= 16'd0;
            digi_r    <= 16'd0;
            systick_r <= 32'd0;
        end else begin
            systick_r <= systick_r + 32'd1;
            if (wr_s && off_s == OFF_LED) begin
                led_r <= wr_data[15:0];
            end
            if (wr_s && off_s == OFF_DIGI) begin
                digi_r <= wr_data[15:0];
            end
        end
    end

    // Digit scan: AN and BCD load together so digit and segments never mismatch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            idx_r      <= 2'd0;
            an_r       <= 4'b1110;
            bcd_r      <= 8'hC0;
        end else if (scan_last_s) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_nx_s;
            an_r       <= ~(4'b0001 << idx_nx_s);
            bcd_r      <= digit_code(idx_nx_s, digi_r);
        end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
        end
    end

    assign led = led_r;
    assign AN  = an_r;
    assign BCD = bcd_r;
    assign irq = tcon_r[2] & tcon_r[1];

endmodule

// File: tb/tb_mmio_peripheral.sv
// Directed self-checking bench for mmio_peripheral, built with SCAN_DIV=4.
module tb_mmio_peripheral;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_DIGI    = 32'h4000_0010;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
    localparam logic [31:0] A_UNMAP   = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rd_data;
    logic [15:0] led;
    logic [3:0]  AN;
    logic [7:0]  BCD;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_peripheral #(.SCAN_DIV(4), .BASE_ADDR(32'h4000_0000)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
        .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data),
        .led(led), .AN(AN), .BCD(BCD), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wr_data = d; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; mem_read = 1'b1;
        #1;
        d = rd_data;
        mem_read = 1'b0;
    endtask

    // Wait (bounded) for the scan to step into digit 0, leaving us at the negedge after that step.
    task automatic sync_digit0(input string tag);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = AN;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (AN == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = AN;
        end
        check_value(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic check_scan(input string tag, input logic [7:0] exp_bcd [4]);
        for (int k = 0; k < 8; k++) begin
            check_value({tag, "_an"}, {28'd0, AN}, {28'd0, ~(4'b0001 << (k % 4))});
            check_value({tag, "_bcd"}, {24'd0, BCD}, {24'd0, exp_bcd[k % 4]});
            repeat (4) @(negedge clk);
        end
    endtask

    logic [31:0] rv;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [7:0]  exp4 [4];

    initial begin
        // 1. Reset and bus
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_value("rst_an", {28'd0, AN}, 32'h0000_000E);
        check_value("rst_bcd", {24'd0, BCD}, 32'h0000_00C0);
        check_value("rst_led", {16'd0, led}, 32'd0);
        check_value("rst_irq", {31'd0, irq}, 32'd0);
        bus_read(A_LED, rv);  check_value("rst_rd_led", rv, 32'd0);
        bus_read(A_TCON, rv); check_value("rst_rd_tcon", rv, 32'd0);
        bus_read(A_DIGI, rv); check_value("rst_rd_digi", rv, 32'd0);

        bus_write(A_LED, 32'h0000_ABCD);
        check_value("led_out", {16'd0, led}, 32'h0000_ABCD);
        bus_read(A_LED, rv);   check_value("led_rd", rv, 32'h0000_ABCD);
        bus_read(A_UNMAP, rv); check_value("unmapped_rd", rv, 32'd0);
        bus_read(32'h5000_000C, rv); check_value("out_window_rd", rv, 32'd0);
        addr = A_LED; mem_read = 1'b0; #1;
        check_value("no_strobe_rd", rd_data, 32'd0);

        // 2. Timer reload and irq
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h0000_0003);
        bus_read(A_TL, rv); check_value("tl_start", rv, 32'hFFFF_FFFE);
        check_value("irq_low0", {31'd0, irq}, 32'd0);
        @(negedge clk);
        bus_read(A_TL, rv); check_value("tl_max", rv, 32'hFFFF_FFFF);
        check_value("irq_low1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        bus_read(A_TL, rv); check_value("tl_reload", rv, 32'hFFFF_FFFC);
        check_value("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(A_TCON, rv); check_value("tcon_status", rv, 32'h0000_0007);
        @(negedge clk);
        bus_read(A_TL, rv); check_value("tl_after", rv, 32'hFFFF_FFFD);
        check_value("irq_hold", {31'd0, irq}, 32'd1);
        bus_write(A_TCON, 32'h0000_0003);
        check_value("irq_clear", {31'd0, irq}, 32'd0);

        // 3. Write priority over increment
        bus_write(A_TCON, 32'h0000_0001);
        bus_write(A_TL, 32'h0000_0005);
        bus_read(A_TL, rv); check_value("tl_wr_wins", rv, 32'h0000_0005);
        @(negedge clk);
        bus_read(A_TL, rv); check_value("tl_wr_next", rv, 32'h0000_0006);
        bus_write(A_TCON, 32'h0000_0000);
        bus_read(A_TL, rv); t0 = rv;
        repeat (3) @(negedge clk);
        bus_read(A_TL, rv); check_value("tl_hold", rv, t0);

        // 4. Display scan
        bus_write(A_DIGI, 32'h0000_1A2F);
        sync_digit0("scan_sync1");
        exp4[0] = 8'h8E; exp4[1] = 8'hA4; exp4[2] = 8'h88; exp4[3] = 8'hF9;
        check_scan("scan1a2f", exp4);

        // 5. SYSTICK
        bus_read(A_SYSTICK, t0);
        repeat (10) @(negedge clk);
        bus_read(A_SYSTICK, t1);
        check_value("systick_delta", t1 - t0, 32'd10);
        bus_read(A_SYSTICK, t0);
        bus_write(A_SYSTICK, 32'h0000_0000);
        bus_read(A_SYSTICK, t1);
        check_value("systick_wr_ignored", t1 - t0, 32'd2);

        // 6. Leading digits and mid-operation reset
        bus_write(A_DIGI, 32'h0000_0012);
        sync_digit0("scan_sync2");
        exp4[0] = 8'hA4; exp4[1] = 8'hF9;
`ifdef LEADING_ZERO_BLANK_EN
        exp4[2] = 8'hFF; exp4[3] = 8'hFF;
`else
        exp4[2] = 8'hC0; exp4[3] = 8'hC0;
`endif
        check_scan("scan0012", exp4);

        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h0000_0003);
        @(negedge clk);
        check_value("irq_pre_reset", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_value("mid_rst_irq", {31'd0, irq}, 32'd0);
        bus_read(A_TL, rv); check_value("mid_rst_tl", rv, 32'd0);
        check_value("mid_rst_an", {28'd0, AN}, 32'h0000_000E);
        check_value("mid_rst_bcd", {24'd0, BCD}, 32'h0000_00C0);
        check_value("mid_rst_led", {16'd0, led}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
